// File: rtl/tsip_pkg.sv
// Shared TSIP framing constants, Primary Timing byte offsets and the
// decoder state encoding used by the destuffer and the field-capture logic.
package tsip_pkg;

    localparam logic [7:0] DLE                = 8'h10;
    localparam logic [7:0] ETX                = 8'h03;
    localparam logic [7:0] ID_PRIMARY_TIMING  = 8'h8F;
    localparam logic [7:0] SUB_PRIMARY_TIMING = 8'hAB;
    localparam logic [4:0] PRIMARY_LEN        = 5'd18;

    // Unstuffed byte offsets inside a Primary Timing packet (index 0 = ID)
    localparam logic [4:0] OFS_SUBCODE = 5'd1;
    localparam logic [4:0] OFS_SECONDS = 5'd11;
    localparam logic [4:0] OFS_MINUTES = 5'd12;
    localparam logic [4:0] OFS_HOURS   = 5'd13;
    localparam logic [4:0] OFS_DAY     = 5'd14;
    localparam logic [4:0] OFS_MONTH   = 5'd15;
    localparam logic [4:0] OFS_YEAR_H  = 5'd16;
    localparam logic [4:0] OFS_YEAR_L  = 5'd17;

    // Index saturation point; a longer packet must never alias back to 18
    localparam logic [4:0] IDX_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ID       = 2'd1,
        DATA     = 2'd2,
        DATA_DLE = 2'd3
    } tsip_state_t;

    // True when the captured ID/subcode pair names the Primary Timing packet
    function automatic logic is_primary_timing(input logic [7:0] id, input logic [7:0] sub);
        return (id == ID_PRIMARY_TIMING) && (sub == SUB_PRIMARY_TIMING);
    endfunction

endpackage

// File: rtl/tsip_destuffer.sv
// TSIP framing state machine: finds packet starts, removes DLE stuffing and
// reports ID bytes (sop), payload bytes (data_dv) and DLE-ETX (eop).
// The strobes are decoded from the current state and the incoming byte so
// that the consumer can register its result on the edge that samples ETX.
module tsip_destuffer
    import tsip_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       timeout,
    output logic       busy,
    output logic       data_dv,
    output logic [7:0] data,
    output logic       sop,
    output logic       eop
);

    tsip_state_t state_r;

    // Framing state register; a received byte always wins over the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (rx_dv) begin
            case (state_r)
                IDLE:     state_r <= (rx_byte == DLE) ? ID : IDLE;
                ID:       state_r <= ((rx_byte == DLE) || (rx_byte == ETX)) ? IDLE : DATA;
                DATA:     state_r <= (rx_byte == DLE) ? DATA_DLE : DATA;
                DATA_DLE: state_r <= (rx_byte == ETX) ? IDLE : DATA;
                default:  state_r <= IDLE;
            endcase
        end else if (timeout) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_r;
        end
    end

    // Unstuffed byte strobes; DLE followed by a non-DLE/ETX byte resyncs as a new ID
    always_comb begin
        data_dv = 1'b0;
        sop     = 1'b0;
        eop     = 1'b0;
        data    = rx_byte;
        if (rx_dv) begin
            case (state_r)
                ID: begin
                    if ((rx_byte != DLE) && (rx_byte != ETX)) begin
                        sop     = 1'b1;
                        data_dv = 1'b1;
                    end else begin
                        sop     = 1'b0;
                    end
                end
                DATA: begin
                    if (rx_byte != DLE) begin
                        data_dv = 1'b1;
                    end else begin
                        data_dv = 1'b0;
                    end
                end
                DATA_DLE: begin
                    if (rx_byte == DLE) begin
                        data_dv = 1'b1;
                    end else if (rx_byte == ETX) begin
                        eop     = 1'b1;
                    end else begin
                        sop     = 1'b1;
                        data_dv = 1'b1;
                    end
                end
                default: begin
                    data_dv = 1'b0;
                end
            endcase
        end else begin
            data_dv = 1'b0;
        end
    end

    assign busy = (state_r != IDLE);

endmodule

// File: rtl/thunderbolt_tsip_decoder.sv
// Thunderbolt TSIP decoder: captures the UTC fields of Primary Timing
// (0x8F-AB) packets into shadow registers and publishes them, with a
// one-cycle strobe, only when a correctly sized packet closes with DLE-ETX.
module thunderbolt_tsip_decoder
    import tsip_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 10_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic        o_thunder_packet_dv,
    output logic [15:0] o_thunder_year,
    output logic [7:0]  o_thunder_month,
    output logic [7:0]  o_thunder_day,
    output logic [7:0]  o_thunder_hour,
    output logic [7:0]  o_thunder_minutes,
    output logic [7:0]  o_thunder_seconds,
    output logic        o_pkt_err
);

    localparam logic [23:0] TIMEOUT_LIM = 24'(TIMEOUT_CLKS);

    logic        busy_s, data_dv_s, sop_s, eop_s, timeout_s;
    logic [7:0]  data_s;
    logic        accept_s, reject_s, primary_s;
    logic [23:0] idle_cnt_r;
    logic [4:0]  index_r;
    logic [7:0]  id_r, sub_r;
    logic [7:0]  sh_sec_r, sh_min_r, sh_hour_r, sh_day_r, sh_month_r;
    logic [15:0] sh_year_r;
    logic        pkt_dv_r, pkt_err_r;
    logic [15:0] year_r;
    logic [7:0]  month_r, day_r, hour_r, min_r, sec_r;

    tsip_destuffer u_destuffer (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .rx_dv   (i_rx_dv),
        .rx_byte (i_rx_byte),
        .timeout (timeout_s),
        .busy    (busy_s),
        .data_dv (data_dv_s),
        .data    (data_s),
        .sop     (sop_s),
        .eop     (eop_s)
    );

    assign timeout_s = busy_s && !i_rx_dv && (idle_cnt_r == TIMEOUT_LIM);
    assign primary_s = is_primary_timing(id_r, sub_r);
    assign accept_s  = eop_s && primary_s && (index_r == PRIMARY_LEN);
    assign reject_s  = eop_s && primary_s && (index_r != PRIMARY_LEN);

    // Inter-byte idle counter, only running while a packet is open
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            idle_cnt_r <= 24'd0;
        end else if (i_rx_dv || !busy_s) begin
            idle_cnt_r <= 24'd0;
        end else if (idle_cnt_r != TIMEOUT_LIM) begin
            idle_cnt_r <= idle_cnt_r + 24'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // ID/subcode capture, saturating byte index and time-field shadows
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            index_r    <= 5'd0;
            id_r       <= 8'd0;
            sub_r      <= 8'd0;
            sh_sec_r   <= 8'd0;
            sh_min_r   <= 8'd0;
            sh_hour_r  <= 8'd0;
            sh_day_r   <= 8'd0;
            sh_month_r <= 8'd0;
            sh_year_r  <= 16'd0;
        end else if (sop_s) begin
            // subcode cleared so a one-byte 0x8F packet never matches a stale 0xAB
            id_r    <= data_s;
            sub_r   <= 8'd0;
            index_r <= 5'd1;
        end else if (data_dv_s) begin
            case (index_r)
                OFS_SUBCODE: sub_r            <= data_s;
                OFS_SECONDS: sh_sec_r         <= data_s;
                OFS_MINUTES: sh_min_r         <= data_s;
                OFS_HOURS:   sh_hour_r        <= data_s;
                OFS_DAY:     sh_day_r         <= data_s;
                OFS_MONTH:   sh_month_r       <= data_s;
                OFS_YEAR_H:  sh_year_r[15:8]  <= data_s;
                OFS_YEAR_L:  sh_year_r[7:0]   <= data_s;
                default:     sub_r            <= sub_r;
            endcase
            index_r <= (index_r == IDX_MAX) ? IDX_MAX : (index_r + 5'd1);
        end else begin
            index_r <= index_r;
        end
    end

    // Published time fields and result strobes, updated only on acceptance
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pkt_dv_r  <= 1'b0;
            pkt_err_r <= 1'b0;
            year_r    <= 16'd0;
            month_r   <= 8'd0;
            day_r     <= 8'd0;
            hour_r    <= 8'd0;
            min_r     <= 8'd0;
            sec_r     <= 8'd0;
        end else begin
            pkt_dv_r  <= accept_s;
            pkt_err_r <= reject_s;
            if (accept_s) begin
                year_r  <= sh_year_r;
                month_r <= sh_month_r;
                day_r   <= sh_day_r;
                hour_r  <= sh_hour_r;
                min_r   <= sh_min_r;
                sec_r   <= sh_sec_r;
            end else begin
                year_r  <= year_r;
            end
        end
    end

    assign o_thunder_packet_dv = pkt_dv_r;
    assign o_pkt_err           = pkt_err_r;
    assign o_thunder_year      = year_r;
    assign o_thunder_month     = month_r;
    assign o_thunder_day       = day_r;
    assign o_thunder_hour      = hour_r;
    assign o_thunder_minutes   = min_r;
    assign o_thunder_seconds   = sec_r;

endmodule
